// File: rtl/sync_fifo_wr_arbiter_if.sv
// Producer-side handshake and FIFO write-port bundle shared by the write arbiter.
// The arbiter takes the slave view; the producers and FIFO together take the master view.
interface sync_fifo_wr_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 16
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_write;
   logic [DATA_WIDTH-1:0]         fifo_data_in;
   logic [2:0]                    grant_id;
   logic                          burst_active;

   modport master (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_write, fifo_data_in, grant_id, burst_active
   );

   modport slave (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_write, fifo_data_in, grant_id, burst_active
   );
endinterface

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one synchronous FIFO write port among NUM_REQ producers.
// An owner keeps the port for up to MAX_BURST beats; writes are suppressed while the FIFO is full.
module sync_fifo_wr_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   sync_fifo_wr_arbiter_if.slave bus
);

   localparam logic [3:0] BURST_LEN  = 4'(MAX_BURST);
   localparam logic [2:0] LAST_RESET = 3'(NUM_REQ - 1);

   typedef enum logic {ST_IDLE, ST_BURST} state_e;

   state_e     state_q, state_d;
   logic [2:0] last_owner_q, last_owner_d;
   logic [2:0] owner_q, owner_d;
   logic [3:0] beat_cnt_q, beat_cnt_d;

   logic [2:0]            sel_idle;
   logic                  found;
   logic                  owner_vld;
   logic [2:0]            sel;
   logic                  sel_vld;
   logic [NUM_REQ-1:0]    ready;
   logic                  xfer;
   logic [DATA_WIDTH-1:0] data_mux;

   // Select the next requester after last_owner, plus the per-producer accept and write mux.
   always_comb begin
      sel_idle  = '0;
      found     = 1'b0;
      owner_vld = 1'b0;
      sel       = '0;
      sel_vld   = 1'b0;
      ready     = '0;
      data_mux  = '0;

      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req_valid[i] &&
                (i == ((32'(last_owner_q) + k) % NUM_REQ))) begin
               sel_idle = 3'(i);
               found    = 1'b1;
            end
         end
      end

      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (3'(i) == owner_q) owner_vld = bus.req_valid[i];
      end

      if (state_q == ST_BURST) begin
         sel     = owner_q;
         sel_vld = owner_vld;
      end else begin
         sel     = sel_idle;
         sel_vld = |bus.req_valid;
      end

      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         ready[i] = (3'(i) == sel) && sel_vld && !bus.fifo_full && !reset;
      end

      xfer = |(bus.req_valid & ready);

      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (xfer && (3'(i) == sel)) data_mux = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign bus.req_ready    = ready;
   assign bus.fifo_write   = xfer;
   assign bus.fifo_data_in = data_mux;
   assign bus.grant_id     = owner_q;
   assign bus.burst_active = (state_q == ST_BURST);

   // Next-state: grant on an IDLE transfer, count beats in BURST, drop out on expiry or lost valid.
   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      owner_d      = owner_q;
      beat_cnt_d   = beat_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               owner_d      = sel;
               last_owner_d = sel;
               beat_cnt_d   = 4'd1;
               state_d      = (MAX_BURST > 1) ? ST_BURST : ST_IDLE;
            end
         end
         ST_BURST: begin
            if (xfer) begin
               if (beat_cnt_q + 4'd1 == BURST_LEN) begin
                  state_d    = ST_IDLE;
                  beat_cnt_d = 4'd0;
               end else begin
                  beat_cnt_d = beat_cnt_q + 4'd1;
               end
            end else if (!owner_vld) begin
               state_d    = ST_IDLE;
               beat_cnt_d = 4'd0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_owner_q <= LAST_RESET;
         owner_q      <= 3'd0;
         beat_cnt_q   <= 4'd0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         owner_q      <= owner_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Directed bench for sync_fifo_wr_arbiter: a per-cycle vector table plus rotation and FIFO-full sequences.
module tb_sync_fifo_wr_arbiter;

   localparam logic [63:0] DATA_FIXED = {16'h4400, 16'h3300, 16'h2200, 16'h1100};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sync_fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(16)) bus ();

   sync_fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .MAX_BURST(4)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   typedef struct packed {
      logic        rst;
      logic [3:0]  v;
      logic        full;
      logic [3:0]  rdy;
      logic        wr;
      logic [15:0] data;
      logic [2:0]  gid;
      logic        burst;
   } vec_t;

   localparam int NVEC = 40;
   vec_t tbl [NVEC];

   int checks   = 0;
   int failures = 0;

   function automatic vec_t mk(input logic r, input logic [3:0] v, input logic f,
                               input logic [3:0] rd, input logic w, input logic [15:0] d,
                               input logic [2:0] g, input logic b);
      vec_t x;
      x.rst = r; x.v = v; x.full = f; x.rdy = rd; x.wr = w; x.data = d; x.gid = g; x.burst = b;
      return x;
   endfunction

   task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d actual=%0h expected=%0h", name, row, act, exp);
      end
   endtask

   // Drive inputs on the falling edge, then settle just before the next rising edge.
   task automatic apply(input logic r, input logic [3:0] v, input logic f);
      @(negedge clk);
      rst           = r;
      bus.req_valid = v;
      bus.fifo_full = f;
      #4;
   endtask

   initial begin
      logic [11:0] seq [4];
      int          exp_p, exp_s, cnt;
      logic        exp_wr;

      // Two-producer bursts, owner drop, full stall, back-to-back single owner.
      tbl[0]  = mk(1, 4'b0101, 0, 4'b0000, 0, 16'h0000, 3'd0, 0);
      tbl[1]  = mk(0, 4'b0101, 0, 4'b0001, 1, 16'h1100, 3'd0, 0);
      tbl[2]  = mk(0, 4'b0101, 0, 4'b0001, 1, 16'h1100, 3'd0, 1);
      tbl[3]  = mk(0, 4'b0101, 0, 4'b0001, 1, 16'h1100, 3'd0, 1);
      tbl[4]  = mk(0, 4'b0101, 0, 4'b0001, 1, 16'h1100, 3'd0, 1);
      tbl[5]  = mk(0, 4'b0101, 0, 4'b0100, 1, 16'h3300, 3'd0, 0);
      tbl[6]  = mk(0, 4'b0101, 0, 4'b0100, 1, 16'h3300, 3'd2, 1);
      tbl[7]  = mk(0, 4'b0101, 0, 4'b0100, 1, 16'h3300, 3'd2, 1);
      tbl[8]  = mk(0, 4'b0101, 0, 4'b0100, 1, 16'h3300, 3'd2, 1);
      tbl[9]  = mk(0, 4'b0101, 0, 4'b0001, 1, 16'h1100, 3'd2, 0);
      tbl[10] = mk(0, 4'b0101, 0, 4'b0001, 1, 16'h1100, 3'd0, 1);
      tbl[11] = mk(0, 4'b0100, 0, 4'b0000, 0, 16'h0000, 3'd0, 1);
      tbl[12] = mk(0, 4'b0100, 0, 4'b0100, 1, 16'h3300, 3'd0, 0);
      tbl[13] = mk(0, 4'b0100, 1, 4'b0000, 0, 16'h0000, 3'd2, 1);
      tbl[14] = mk(0, 4'b0100, 1, 4'b0000, 0, 16'h0000, 3'd2, 1);
      tbl[15] = mk(0, 4'b0100, 0, 4'b0100, 1, 16'h3300, 3'd2, 1);
      tbl[16] = mk(0, 4'b0100, 0, 4'b0100, 1, 16'h3300, 3'd2, 1);
      tbl[17] = mk(0, 4'b0100, 0, 4'b0100, 1, 16'h3300, 3'd2, 1);
      tbl[18] = mk(0, 4'b0100, 0, 4'b0100, 1, 16'h3300, 3'd2, 0);
      tbl[19] = mk(0, 4'b1100, 0, 4'b0100, 1, 16'h3300, 3'd2, 1);
      tbl[20] = mk(1, 4'b1111, 0, 4'b0000, 0, 16'h0000, 3'd2, 1);
      tbl[21] = mk(0, 4'b1111, 0, 4'b0001, 1, 16'h1100, 3'd0, 0);
      tbl[22] = mk(0, 4'b1111, 0, 4'b0001, 1, 16'h1100, 3'd0, 1);
      tbl[23] = mk(0, 4'b1111, 0, 4'b0001, 1, 16'h1100, 3'd0, 1);
      tbl[24] = mk(0, 4'b1111, 0, 4'b0001, 1, 16'h1100, 3'd0, 1);
      tbl[25] = mk(0, 4'b1111, 0, 4'b0010, 1, 16'h2200, 3'd0, 0);
      tbl[26] = mk(0, 4'b1111, 0, 4'b0010, 1, 16'h2200, 3'd1, 1);
      tbl[27] = mk(0, 4'b1111, 0, 4'b0010, 1, 16'h2200, 3'd1, 1);
      tbl[28] = mk(0, 4'b1111, 0, 4'b0010, 1, 16'h2200, 3'd1, 1);
      tbl[29] = mk(0, 4'b1111, 1, 4'b0000, 0, 16'h0000, 3'd1, 0);
      tbl[30] = mk(0, 4'b1100, 0, 4'b0100, 1, 16'h3300, 3'd1, 0);
      tbl[31] = mk(0, 4'b1100, 0, 4'b0100, 1, 16'h3300, 3'd2, 1);
      tbl[32] = mk(0, 4'b1100, 0, 4'b0100, 1, 16'h3300, 3'd2, 1);
      tbl[33] = mk(0, 4'b1100, 0, 4'b0100, 1, 16'h3300, 3'd2, 1);
      tbl[34] = mk(0, 4'b1001, 0, 4'b1000, 1, 16'h4400, 3'd2, 0);
      tbl[35] = mk(0, 4'b1001, 0, 4'b1000, 1, 16'h4400, 3'd3, 1);
      tbl[36] = mk(0, 4'b0001, 0, 4'b0000, 0, 16'h0000, 3'd3, 1);
      tbl[37] = mk(0, 4'b0001, 0, 4'b0001, 1, 16'h1100, 3'd3, 0);
      tbl[38] = mk(0, 4'b0000, 0, 4'b0000, 0, 16'h0000, 3'd0, 1);
      tbl[39] = mk(0, 4'b0000, 0, 4'b0000, 0, 16'h0000, 3'd0, 0);

      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_data  = DATA_FIXED;
      bus.fifo_full = 1'b0;
      apply(1'b1, 4'b0000, 1'b0);
      apply(1'b1, 4'b0000, 1'b0);

      for (int n = 0; n < NVEC; n++) begin
         apply(tbl[n].rst, tbl[n].v, tbl[n].full);
         check("ready", n, 32'(bus.req_ready),    32'(tbl[n].rdy));
         check("write", n, 32'(bus.fifo_write),   32'(tbl[n].wr));
         check("data",  n, 32'(bus.fifo_data_in), 32'(tbl[n].data));
         check("grant", n, 32'(bus.grant_id),     32'(tbl[n].gid));
         check("burst", n, 32'(bus.burst_active), 32'(tbl[n].burst));
      end

      // All four producers valid: blocks of four in strict 0,1,2,3 rotation, contiguous sequence numbers.
      for (int i = 0; i < 4; i++) seq[i] = '0;
      apply(1'b1, 4'b0000, 1'b0);
      for (int n = 0; n < 32; n++) begin
         @(negedge clk);
         rst           = 1'b0;
         bus.req_valid = 4'hF;
         bus.fifo_full = 1'b0;
         for (int i = 0; i < 4; i++) bus.req_data[i*16 +: 16] = {4'(i), seq[i]};
         #4;
         exp_p = (n / 4) % 4;
         exp_s = (n / 16) * 4 + (n % 4);
         check("rot_write", n, 32'(bus.fifo_write), 32'd1);
         check("rot_data",  n, 32'(bus.fifo_data_in), 32'({4'(exp_p), 12'(exp_s)}));
         for (int i = 0; i < 4; i++) if (bus.req_ready[i]) seq[i] = seq[i] + 12'd1;
      end

      // FIFO fills mid-burst of owner 1; one drained slot admits exactly one write that ends the burst.
      bus.req_data = DATA_FIXED;
      apply(1'b1, 4'b0000, 1'b0);
      cnt = 29;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c == 6) cnt = cnt - 1;
         rst           = 1'b0;
         bus.req_valid = 4'b0010;
         bus.fifo_full = (cnt == 32);
         #4;
         exp_wr = (c < 3) || (c == 6);
         check("full_write", c, 32'(bus.fifo_write), 32'(exp_wr));
         check("full_ready", c, 32'(bus.req_ready), exp_wr ? 32'h2 : 32'h0);
         check("full_data",  c, 32'(bus.fifo_data_in), exp_wr ? 32'h2200 : 32'h0);
         check("full_burst", c, 32'(bus.burst_active), 32'((c >= 1) && (c <= 6)));
         check("full_grant", c, 32'(bus.grant_id), (c == 0) ? 32'd0 : 32'd1);
         if (bus.fifo_write) cnt = cnt + 1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
